audio_minmax_stream: RTL and testbench

Parametrised, multi-channel successor to the single-array min/max block. It consumes a window of WIN_LEN signed samples per channel over a valid/ready stream instead of a fully parallel array, and tracks running maximum and minimum for every channel. It then presents registered results with a done flag. It sits between the audio sample front-end and the normalisation/threshold stages.

---
 rtl/audio_minmax_pkg.sv | 19 +
 rtl/audio_minmax_stream_lane.sv | 77 +++++++
 rtl/audio_minmax_stream.sv | 115 +++++++++++
 tb/tb_audio_minmax_stream.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_minmax_pkg.sv
// rtl/audio_minmax_pkg.sv - shared types, default sizes and channel slice helper
package audio_minmax_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_CH  = 2;
    localparam int DEF_WIN_LEN = 100;

    // bit offset of channel ch inside a packed multi-channel word
    function automatic int ch_offset(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/audio_minmax_stream_lane.sv
// rtl/audio_minmax_stream_lane.sv - one channel running max/min tracker (AUDIO_MINMAX_INDEX_EN adds beat indices)
module minmax_lane #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     update,
    input  logic signed [DATA_W-1:0] sample,
`ifdef AUDIO_MINMAX_INDEX_EN
    input  logic [CNT_W-1:0]         idx,
    output logic [CNT_W-1:0]         nxt_max_idx,
    output logic [CNT_W-1:0]         nxt_min_idx,
`endif
    output logic signed [DATA_W-1:0] nxt_max,
    output logic signed [DATA_W-1:0] nxt_min
);

    logic signed [DATA_W-1:0] cur_max;
    logic signed [DATA_W-1:0] cur_min;
`ifdef AUDIO_MINMAX_INDEX_EN
    logic [CNT_W-1:0] cur_max_idx;
    logic [CNT_W-1:0] cur_min_idx;
`endif

    // next running extremes; strict compares so ties keep the earlier beat
    always_comb begin
        nxt_max = cur_max;
        nxt_min = cur_min;
`ifdef AUDIO_MINMAX_INDEX_EN
        nxt_max_idx = cur_max_idx;
        nxt_min_idx = cur_min_idx;
`endif
        if (load) begin
            nxt_max = sample;
            nxt_min = sample;
`ifdef AUDIO_MINMAX_INDEX_EN
            nxt_max_idx = idx;
            nxt_min_idx = idx;
`endif
        end else begin
            if (sample > cur_max) begin
                nxt_max = sample;
`ifdef AUDIO_MINMAX_INDEX_EN
                nxt_max_idx = idx;
`endif
            end
            if (sample < cur_min) begin
                nxt_min = sample;
`ifdef AUDIO_MINMAX_INDEX_EN
                nxt_min_idx = idx;
`endif
            end
        end
    end

    // commit the running extremes on every accepted beat
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_max <= '0;
            cur_min <= '0;
`ifdef AUDIO_MINMAX_INDEX_EN
            cur_max_idx <= '0;
            cur_min_idx <= '0;
`endif
        end else if (update) begin
            cur_max <= nxt_max;
            cur_min <= nxt_min;
`ifdef AUDIO_MINMAX_INDEX_EN
            cur_max_idx <= nxt_max_idx;
            cur_min_idx <= nxt_min_idx;
`endif
        end
    end

endmodule

// File: rtl/audio_minmax_stream.sv
// rtl/audio_minmax_stream.sv - windowed multi-channel min/max over a valid/ready stream (AUDIO_MINMAX_INDEX_EN adds index outputs)
module audio_minmax_stream
    import audio_minmax_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int CNT_W   = $clog2(WIN_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     busy,
    output logic                     d,
`ifdef AUDIO_MINMAX_INDEX_EN
    output logic [NUM_CH*CNT_W-1:0]  out_max_idx,
    output logic [NUM_CH*CNT_W-1:0]  out_min_idx,
`endif
    output logic [NUM_CH*DATA_W-1:0] out_max,
    output logic [NUM_CH*DATA_W-1:0] out_min
);

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic                     accept;
    logic                     first_beat;
    logic                     last_beat;
    logic [NUM_CH*DATA_W-1:0] nxt_max;
    logic [NUM_CH*DATA_W-1:0] nxt_min;
`ifdef AUDIO_MINMAX_INDEX_EN
    logic [NUM_CH*CNT_W-1:0]  nxt_max_idx;
    logic [NUM_CH*CNT_W-1:0]  nxt_min_idx;
`endif

    assign accept     = in_valid && in_ready;
    assign first_beat = (cnt == '0);
    assign last_beat  = (cnt == CNT_W'(WIN_LEN - 1));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        minmax_lane #(
            .DATA_W(DATA_W),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .load       (first_beat),
            .update     (accept),
            .sample     (in_data[ch_offset(c, DATA_W) +: DATA_W]),
`ifdef AUDIO_MINMAX_INDEX_EN
            .idx        (cnt),
            .nxt_max_idx(nxt_max_idx[ch_offset(c, CNT_W) +: CNT_W]),
            .nxt_min_idx(nxt_min_idx[ch_offset(c, CNT_W) +: CNT_W]),
`endif
            .nxt_max    (nxt_max[ch_offset(c, DATA_W) +: DATA_W]),
            .nxt_min    (nxt_min[ch_offset(c, DATA_W) +: DATA_W])
        );
    end

    // window FSM; results are captured from the lanes' next values on the last beat
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            d        <= 1'b0;
            out_max  <= '0;
            out_min  <= '0;
`ifdef AUDIO_MINMAX_INDEX_EN
            out_max_idx <= '0;
            out_min_idx <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        d        <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_beat) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            d        <= 1'b1;
                            out_max  <= nxt_max;
                            out_min  <= nxt_min;
`ifdef AUDIO_MINMAX_INDEX_EN
                            out_max_idx <= nxt_max_idx;
                            out_min_idx <= nxt_min_idx;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    d        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_minmax_stream.sv
// tb/tb_audio_minmax_stream.sv - scoreboard bench for audio_minmax_stream (WIN_LEN=100 and WIN_LEN=1 instances)
module tb_audio_minmax_stream;

    typedef struct {
        logic [63:0] mx;
        logic [63:0] mn;
        logic [13:0] mxi;
        logic [13:0] mni;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        busy;
    logic        d;
    logic [63:0] out_max;
    logic [63:0] out_min;

    logic        start1;
    logic        in_valid1;
    logic        in_ready1;
    logic [63:0] in_data1;
    logic        busy1;
    logic        d1;
    logic [63:0] out_max1;
    logic [63:0] out_min1;

`ifdef AUDIO_MINMAX_INDEX_EN
    logic [13:0] out_max_idx;
    logic [13:0] out_min_idx;
    logic [1:0]  out_max_idx1;
    logic [1:0]  out_min_idx1;
`endif

    exp_t        q0[$];
    exp_t        q1[$];
    int          tests;
    int          fails;
    logic [31:0] s0[100];
    logic [31:0] s1[100];

    audio_minmax_stream #(.DATA_W(32), .NUM_CH(2), .WIN_LEN(100)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .busy(busy), .d(d),
`ifdef AUDIO_MINMAX_INDEX_EN
        .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
`endif
        .out_max(out_max), .out_min(out_min)
    );

    audio_minmax_stream #(.DATA_W(32), .NUM_CH(2), .WIN_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1),
        .in_ready(in_ready1), .in_data(in_data1), .busy(busy1), .d(d1),
`ifdef AUDIO_MINMAX_INDEX_EN
        .out_max_idx(out_max_idx1), .out_min_idx(out_min_idx1),
`endif
        .out_max(out_max1), .out_min(out_min1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor for the WIN_LEN=100 instance
    initial begin
        logic d_prev;
        exp_t e;
        d_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (d && !d_prev) begin
                if (q0.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = q0.pop_front();
                    check("out_max", out_max, e.mx);
                    check("out_min", out_min, e.mn);
`ifdef AUDIO_MINMAX_INDEX_EN
                    check("out_max_idx", 64'(out_max_idx), 64'(e.mxi));
                    check("out_min_idx", 64'(out_min_idx), 64'(e.mni));
`endif
                end
            end
            d_prev = d;
        end
    end

    // scoreboard monitor for the WIN_LEN=1 instance
    initial begin
        logic d_prev;
        exp_t e;
        d_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (d1 && !d_prev) begin
                if (q1.size() == 0) begin
                    check("unexpected_done1", 64'd1, 64'd0);
                end else begin
                    e = q1.pop_front();
                    check("w1_out_max", out_max1, e.mx);
                    check("w1_out_min", out_min1, e.mn);
`ifdef AUDIO_MINMAX_INDEX_EN
                    check("w1_out_max_idx", 64'(out_max_idx1), 64'd0);
                    check("w1_out_min_idx", 64'(out_min_idx1), 64'd0);
`endif
                end
            end
            d_prev = d1;
        end
    end

    task automatic push(input logic [63:0] mx, input logic [63:0] mn,
                        input logic [13:0] mxi, input logic [13:0] mni);
        exp_t e;
        e.mx = mx; e.mn = mn; e.mxi = mxi; e.mni = mni;
        q0.push_back(e);
    endtask

    // caller is aligned #1 after a rising edge; start_at = beat on which start is also raised
    task automatic send_window(input bit bp, input int start_at);
        int acc;
        int cyc;
        bit tog;
        bit got;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("d_after_start", 64'(d), 64'd0);
        check("busy_after_start", 64'(busy), 64'd1);
        check("ready_after_start", 64'(in_ready), 64'd1);
        acc = 0; cyc = 0; tog = 1'b1;
        while (acc < 100 && cyc < 1000) begin
            in_valid = bp ? tog : 1'b1;
            tog = !tog;
            in_data = {s1[acc], s0[acc]};
            start = (acc == start_at && in_valid) ? 1'b1 : 1'b0;
            got = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (got) begin
                acc++;
                if (acc == 99) check("d_before_last", 64'(d), 64'd0);
                if (acc == start_at + 1) check("busy_after_run_start", 64'(busy), 64'd1);
            end
        end
        in_valid = 1'b0;
        if (cyc >= 1000) check("window_timeout", 64'd1, 64'd0);
        check("d_after_last", 64'(d), 64'd1);
        check("busy_after_last", 64'(busy), 64'd0);
        check("ready_after_last", 64'(in_ready), 64'd0);
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_d", 64'(d), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_max", out_max, 64'd0);
        check("rst_min", out_min, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // basic ramp
        for (int i = 0; i < 100; i++) begin
            s0[i] = 32'(i - 50);
            s1[i] = 32'(50 - i);
        end
        push({32'd50, 32'd49}, {32'(-49), 32'(-50)}, {7'd0, 7'd99}, {7'd99, 7'd0});
        send_window(1'b0, -1);

        // reset after 40 beats of a new window
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = {s1[i], s0[i]};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_d", 64'(d), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd0);
        check("midrst_max", out_max, 64'd0);
        check("midrst_min", out_min, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // full window after reset
        push({32'd50, 32'd49}, {32'(-49), 32'(-50)}, {7'd0, 7'd99}, {7'd99, 7'd0});
        send_window(1'b0, -1);

        // all-zero window
        for (int i = 0; i < 100; i++) begin
            s0[i] = '0;
            s1[i] = '0;
        end
        push(64'd0, 64'd0, 14'd0, 14'd0);
        send_window(1'b0, -1);

        // backpressure on the ramp
        for (int i = 0; i < 100; i++) begin
            s0[i] = 32'(i - 50);
            s1[i] = 32'(50 - i);
        end
        push({32'd50, 32'd49}, {32'(-49), 32'(-50)}, {7'd0, 7'd99}, {7'd99, 7'd0});
        send_window(1'b1, -1);

        // extremes with start raised mid-window
        for (int i = 0; i < 100; i++) begin
            s0[i] = 32'(i);
            s1[i] = 32'(3 * i);
        end
        s0[10] = 32'h7FFF_FFFF;
        s0[20] = 32'h8000_0000;
        push({32'd297, 32'h7FFF_FFFF}, {32'd0, 32'h8000_0000}, {7'd99, 7'd10}, {7'd0, 7'd20});
        send_window(1'b0, 50);

        // WIN_LEN=1 instance: single beat of -7 on ch0, 5 on ch1
        begin
            exp_t e;
            e.mx = {32'd5, 32'(-7)}; e.mn = {32'd5, 32'(-7)}; e.mxi = '0; e.mni = '0;
            q1.push_back(e);
        end
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("w1_busy_after_start", 64'(busy1), 64'd1);
        check("w1_d_after_start", 64'(d1), 64'd0);
        in_valid1 = 1'b1;
        in_data1 = {32'd5, 32'(-7)};
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check("w1_d_after_beat", 64'(d1), 64'd1);
        check("w1_busy_after_beat", 64'(busy1), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
